// File: rtl/reg_file_param.sv
// DEPTH x DATA_W register file with handshaked write port, two read ports,
// optional write-through bypass and a pending-load scoreboard.
module reg_file_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] rd1_addr,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic [DATA_W-1:0] rd2_data,
  output logic              rd1_busy,
  output logic              rd2_busy,
  output logic [ADDR_W:0]   busy_cnt,
  output logic              init_done
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e            state_q, state_d;
  logic              run_q, run_d;
  logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic run;
  logic wr_acc;
  logic rsv_acc;

  assign run     = (state_q == S_RUN);
  assign wr_acc  = wr_valid & run;
  assign rsv_acc = rsv_valid & run;

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    busy_d     = busy_q;
    mem_d      = mem_q;
    if (!run) begin
      mem_d[init_ptr_q] = '0;
      init_ptr_d        = init_ptr_q + 1'b1;
      if (init_ptr_q == LAST) begin
        state_d = S_RUN;
      end
    end else begin
      if (wr_acc) begin
        mem_d[wr_addr]  = wr_data;
        busy_d[wr_addr] = 1'b0;
      end
      // reserve after write so a same-address collision ends pending
      if (rsv_acc) begin
        busy_d[rsv_addr] = 1'b1;
      end
    end
    run_d = (state_d == S_RUN);
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      run_q      <= 1'b0;
      init_ptr_q <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      init_ptr_q <= init_ptr_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      mem_q      <= mem_d;
    end
  end

  assign wr_ready  = run_q;
  assign init_done = run_q;
  assign busy_cnt  = busy_cnt_q;

  always_comb begin
    rd1_data = '0;
    rd1_busy = 1'b0;
    if (run) begin
      rd1_data = mem_q[rd1_addr];
      rd1_busy = busy_q[rd1_addr];
      if (BYPASS != 0 && wr_acc && wr_addr == rd1_addr) begin
        rd1_data = wr_data;
        rd1_busy = rsv_acc && (rsv_addr == rd1_addr);
      end
    end
  end

  always_comb begin
    rd2_data = '0;
    rd2_busy = 1'b0;
    if (run) begin
      rd2_data = mem_q[rd2_addr];
      rd2_busy = busy_q[rd2_addr];
      if (BYPASS != 0 && wr_acc && wr_addr == rd2_addr) begin
        rd2_data = wr_data;
        rd2_busy = rsv_acc && (rsv_addr == rd2_addr);
      end
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: bypass and non-bypass instances
// share stimulus; a negedge monitor retires queued expectations.
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_valid;
  logic [3:0]  rsv_addr;
  logic [3:0]  rd1_addr;
  logic [3:0]  rd2_addr;

  logic        wr_ready, wr_ready_nb;
  logic [31:0] rd1_data, rd2_data, rd1_data_nb, rd2_data_nb;
  logic        rd1_busy, rd2_busy, rd1_busy_nb, rd2_busy_nb;
  logic [4:0]  busy_cnt, busy_cnt_nb;
  logic        init_done, init_done_nb;

  reg_file_param #(.DATA_W(32), .ADDR_W(4), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd1_data(rd1_data), .rd2_data(rd2_data),
    .rd1_busy(rd1_busy), .rd2_busy(rd2_busy),
    .busy_cnt(busy_cnt), .init_done(init_done)
  );

  reg_file_param #(.DATA_W(32), .ADDR_W(4), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready_nb),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd1_data(rd1_data_nb), .rd2_data(rd2_data_nb),
    .rd1_busy(rd1_busy_nb), .rd2_busy(rd2_busy_nb),
    .busy_cnt(busy_cnt_nb), .init_done(init_done_nb)
  );

  always #5 clk = ~clk;

  localparam int K_RD1D = 0;
  localparam int K_RD2D = 1;
  localparam int K_RD1B = 2;
  localparam int K_RD2B = 3;
  localparam int K_CNT  = 4;
  localparam int K_DONE = 5;
  localparam int K_RDY  = 6;
  localparam int K_NB   = 10;

  typedef struct {
    int          cyc;
    int          kind;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] get_act(input int kind);
    case (kind)
      K_RD1D:        return {32'd0, rd1_data};
      K_RD2D:        return {32'd0, rd2_data};
      K_RD1B:        return {63'd0, rd1_busy};
      K_RD2B:        return {63'd0, rd2_busy};
      K_CNT:         return {59'd0, busy_cnt};
      K_DONE:        return {63'd0, init_done};
      K_RDY:         return {63'd0, wr_ready};
      K_NB + K_RD1D: return {32'd0, rd1_data_nb};
      K_NB + K_RD2D: return {32'd0, rd2_data_nb};
      K_NB + K_RD1B: return {63'd0, rd1_busy_nb};
      K_NB + K_RD2B: return {63'd0, rd2_busy_nb};
      K_NB + K_CNT:  return {59'd0, busy_cnt_nb};
      K_NB + K_DONE: return {63'd0, init_done_nb};
      K_NB + K_RDY:  return {63'd0, wr_ready_nb};
      default:       return 64'hDEAD_DEAD_DEAD_DEAD;
    endcase
  endfunction

  // monitor: retire every expectation tagged for the current cycle
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [63:0] act;
        act = get_act(sb[i].kind);
        checks++;
        if (act !== sb[i].val) begin
          errors++;
          $display("FAIL %s @cyc %0d: got 0x%0h want 0x%0h",
                   sb[i].name, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_now(input int kind, input logic [63:0] v,
                            input string nm);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid  = 1'b0;
    rsv_valid = 1'b0;
  endtask

  task automatic write(input logic [3:0] a, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
  endtask

  // 16 edges of INIT with junk traffic that must be ignored
  task automatic init_wait(input string tag);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k < 16) begin
        write(4'(k), 32'hBAD0_0000 | 32'(k));
        rsv_valid = 1'b1;
        rsv_addr  = 4'(k);
        rd1_addr  = 4'(k);
        rd2_addr  = 4'(15 - k);
        expect_now(K_DONE, 0, {tag, "_init_done_lo"});
        expect_now(K_RDY, 0, {tag, "_wr_ready_lo"});
        expect_now(K_CNT, 0, {tag, "_cnt_init"});
        expect_now(K_RD1D, 0, {tag, "_rd1_init"});
        expect_now(K_RD2B, 0, {tag, "_rd2_busy_init"});
        expect_now(K_NB + K_DONE, 0, {tag, "_nb_init_done_lo"});
      end else begin
        idle_inputs();
        expect_now(K_DONE, 1, {tag, "_init_done_hi"});
        expect_now(K_RDY, 1, {tag, "_wr_ready_hi"});
        expect_now(K_NB + K_DONE, 1, {tag, "_nb_init_done_hi"});
        expect_now(K_NB + K_RDY, 1, {tag, "_nb_wr_ready_hi"});
      end
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      step();
      rd1_addr = 4'(i);
      rd2_addr = 4'(15 - i);
      expect_now(K_RD1D, 0, {tag, "_rd1_zero"});
      expect_now(K_RD2D, 0, {tag, "_rd2_zero"});
      expect_now(K_RD1B, 0, {tag, "_rd1_busy0"});
      expect_now(K_RD2B, 0, {tag, "_rd2_busy0"});
      expect_now(K_NB + K_RD1D, 0, {tag, "_nb_rd1_zero"});
      expect_now(K_NB + K_RD2D, 0, {tag, "_nb_rd2_zero"});
      expect_now(K_NB + K_RD1B, 0, {tag, "_nb_rd1_busy0"});
      expect_now(K_NB + K_RD2B, 0, {tag, "_nb_rd2_busy0"});
    end
    expect_now(K_CNT, 0, {tag, "_cnt_zero"});
    expect_now(K_NB + K_CNT, 0, {tag, "_nb_cnt_zero"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    rd1_addr  = '0;
    rd2_addr  = '0;

    // reset two edges, then clear sequence
    step();
    step();
    expect_now(K_DONE, 0, "rst_init_done");
    expect_now(K_RDY, 0, "rst_wr_ready");
    expect_now(K_CNT, 0, "rst_busy_cnt");
    expect_now(K_RD1D, 0, "rst_rd1_data");
    expect_now(K_RD1B, 0, "rst_rd1_busy");
    expect_now(K_RD2D, 0, "rst_rd2_data");
    rst_n = 1'b1;
    init_wait("boot");
    read_all_zero("boot");

    // write/read with and without bypass
    step();
    write(4'd5, 32'hDEAD_BEEF);
    rd1_addr = 4'd5;
    expect_now(K_RD1D, 64'hDEAD_BEEF, "wr_bypass_same_cyc");
    expect_now(K_NB + K_RD1D, 0, "wr_nobypass_same_cyc");
    step();
    idle_inputs();
    expect_now(K_RD1D, 64'hDEAD_BEEF, "wr_bypass_next");
    expect_now(K_NB + K_RD1D, 64'hDEAD_BEEF, "wr_nobypass_next");

    // scoreboard: reserve r3, r9
    step();
    rsv_valid = 1'b1;
    rsv_addr  = 4'd3;
    rd1_addr  = 4'd3;
    expect_now(K_RD1B, 0, "rsv3_not_yet");
    expect_now(K_CNT, 0, "rsv3_cnt0");
    step();
    rsv_addr = 4'd9;
    expect_now(K_RD1B, 1, "rsv3_busy");
    expect_now(K_CNT, 1, "rsv3_cnt1");
    step();
    idle_inputs();
    rd2_addr = 4'd9;
    expect_now(K_RD1B, 1, "r3_busy");
    expect_now(K_RD2B, 1, "r9_busy");
    expect_now(K_CNT, 2, "busy_cnt2");
    expect_now(K_NB + K_CNT, 2, "nb_busy_cnt2");
    step();
    write(4'd3, 32'h12);
    expect_now(K_RD1B, 0, "wr3_bypass_busy");
    expect_now(K_RD1D, 32'h12, "wr3_bypass_data");
    expect_now(K_NB + K_RD1B, 1, "wr3_nb_busy");
    expect_now(K_NB + K_RD1D, 0, "wr3_nb_data");
    expect_now(K_CNT, 2, "wr3_cnt_lag");
    step();
    idle_inputs();
    expect_now(K_RD1B, 0, "r3_cleared");
    expect_now(K_RD1D, 32'h12, "r3_data");
    expect_now(K_CNT, 1, "busy_cnt1");
    step();
    write(4'd9, 32'h99);
    expect_now(K_RD2B, 0, "wr9_bypass_busy");
    expect_now(K_NB + K_RD2B, 1, "wr9_nb_busy");
    step();
    idle_inputs();
    expect_now(K_CNT, 0, "busy_cnt0");
    expect_now(K_RD2B, 0, "r9_cleared");
    expect_now(K_RD2D, 32'h99, "r9_data");

    // collision: write + reserve r7
    step();
    write(4'd7, 32'hA5);
    rsv_valid = 1'b1;
    rsv_addr  = 4'd7;
    rd1_addr  = 4'd7;
    expect_now(K_RD1D, 32'hA5, "coll_bypass_data");
    expect_now(K_RD1B, 1, "coll_bypass_busy");
    expect_now(K_NB + K_RD1B, 0, "coll_nb_busy");
    step();
    idle_inputs();
    expect_now(K_RD1D, 32'hA5, "coll_data");
    expect_now(K_RD1B, 1, "coll_busy");
    expect_now(K_CNT, 1, "coll_cnt");

    // dual port same register
    step();
    write(4'd12, 32'h1);
    rd1_addr = 4'd12;
    rd2_addr = 4'd12;
    expect_now(K_RD1D, 32'h1, "dual_rd1");
    expect_now(K_RD2D, 32'h1, "dual_rd2");
    expect_now(K_NB + K_RD2D, 0, "dual_nb_rd2");
    step();
    idle_inputs();
    expect_now(K_RD1D, 32'h1, "dual_rd1_next");
    expect_now(K_NB + K_RD2D, 32'h1, "dual_nb_rd2_next");

    // fill all, reserve r4, then pulse reset
    for (int i = 0; i < 16; i++) begin
      step();
      write(4'(i), 32'h100 + 32'(i));
    end
    step();
    idle_inputs();
    rsv_valid = 1'b1;
    rsv_addr  = 4'd4;
    step();
    idle_inputs();
    rd1_addr = 4'd4;
    rd2_addr = 4'd15;
    expect_now(K_CNT, 1, "fill_cnt1");
    expect_now(K_RD1B, 1, "fill_r4_busy");
    expect_now(K_RD1D, 32'h104, "fill_r4_data");
    expect_now(K_RD2D, 32'h10F, "fill_r15_data");
    step();
    rst_n = 1'b0;
    write(4'd4, 32'hBAD);
    step();
    rst_n = 1'b1;
    expect_now(K_RDY, 0, "mid_rst_wr_ready");
    expect_now(K_CNT, 0, "mid_rst_cnt");
    expect_now(K_RD1B, 0, "mid_rst_rd1_busy");
    expect_now(K_RD1D, 0, "mid_rst_rd1_data");
    expect_now(K_NB + K_CNT, 0, "mid_rst_nb_cnt");
    init_wait("rerun");
    read_all_zero("rerun");

    step();
    step();
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
